prt_scaler_vbs: RTL and testbench
=================================

// Module: prt_scaler_vbs
// PURPOSE
//  Vertical bilinear 2x up-scaler; sits directly downstream of the horizontal bilinear scaler.
//  Stores incoming lines in a 4-slot line buffer. Emits each input line k twice on request
//  of the output timing generator: first a copy of k, then avg(k, k+1); the last line is copied twice.
//  Decouples input line rate from the 2x output line rate.
// PARAMETERS
//  P_PPC        4     pixels per clock
//  P_BPC        8     bits per component
//  P_LINE_WORDS 1024  max words per line, power of 2; P_ADR = $clog2(P_LINE_WORDS)
// PORTS
//  CLK_IN         in   1            clock
//  RST_IN         in   1            asynchronous reset, active-low
//  CTL_RUN_IN     in   1            run; low = flush to idle
//  CTL_WORDS_IN   in   P_ADR+1      words per line
//  CTL_LINES_IN   in   16           input lines per frame
//  VS_IN          in   1            input frame start pulse
//  HS_IN          in   1            input line boundary pulse (hbs HS_OUT)
//  DAT_IN         in   P_PPC*P_BPC  input data (hbs DAT_OUT)
//  DE_IN          in   1            input data enable (hbs DE_OUT)
//  RD_VS_IN       in   1            output frame start pulse
//  RD_HS_IN       in   1            output line start pulse
//  RD_DE_IN       in   1            output word request
//  DAT_OUT        out  P_PPC*P_BPC  output data
//  DE_OUT         out  1            output data valid
//  RDY_OUT        out  1            lines 0 and 1 of frame committed, read side may start
//  ERR_OUT        out  1            sticky under/overflow; cleared by CTL_RUN_IN low
// BEHAVIOUR
//  Reset: DAT_OUT=0, DE_OUT=0, RDY_OUT=0, ERR_OUT=0; FSM=S_IDLE; all pointers/counters 0.
//  Write side:
//   - VS_IN: wr_line=0, wr_adr=0, occ=0.
//   - DE_IN: word written at {wr_slot, wr_adr}, wr_adr++; words at wr_adr >= CTL_WORDS_IN dropped.
//   - HS_IN with wr_adr!=0: line committed; wr_slot++ mod 4, wr_line++, occ++, wr_adr=0.
//   - HS_IN and DE_IN in the same cycle: commit first; the word lands at adr 0 of the new line.
//   - Word arriving with occ==4: dropped, ERR_OUT=1.
//  Read FSM:
//   - S_IDLE -> S_SYNC when CTL_RUN_IN=1.
//   - S_SYNC -> S_RUN at the first RD_VS_IN with RDY_OUT=1.
//   - Any state -> S_IDLE when CTL_RUN_IN=0; counters cleared, DE_OUT=0, ERR_OUT cleared.
//  Read side, in S_RUN:
//   - RD_VS_IN: rd_line=0, phase=0.
//   - RD_HS_IN: toggles phase. On 1->0, slot of rd_line freed: occ--, rd_line++.
//   - Commit and free in the same cycle: occ unchanged.
//  Phase 0 output: line rd_line verbatim.
//  Phase 1 output: per component (a+b)>>1, (P_BPC+1)-bit sum, truncating.
//   - a = rd_line, b = rd_line+1.
//   - b = a when rd_line == CTL_LINES_IN-1.
//  RD_DE_IN: rd_adr++, rd_adr=0 at RD_HS_IN.
//  Underrun: line required (phase 0: rd_line; phase 1: rd_line+1) not yet committed at RD_HS_IN.
//   - ERR_OUT=1, DAT_OUT=0 for that whole line; DE_OUT still follows RD_DE_IN.
//  Latency RD_DE_IN -> DE_OUT/DAT_OUT = 3 clocks:
//   - address reg, RAM read (1 cycle), average reg.
//  Outside S_RUN: DE_OUT=0, DAT_OUT=0.
//  RAM contents are don't-care after reset; never read before written.
// STRUCTURE
//  Package prt_scaler_pkg:
//   - vbs_state_t enum {S_IDLE, S_SYNC, S_RUN}
//   - constant P_VBS_SLOTS=4
//   - line-pointer typedef (2-bit slot)
//  Sub-module prt_scaler_vbs_lb:
//   - simple dual-port RAM, 4*P_LINE_WORDS x P_PPC*P_BPC, registered read.
//   - instantiated twice (line a, line b), both written identically.
//  Top:
//   - write control, occupancy counter, read FSM, averaging pipeline.
// TESTING
//  1 Copy: 4 lines of 8 words, line n all components = 16*n, then RD strobes
//    -> 8 output lines: 0,8,16,24,32,40,48,48.
//  2 Rounding: line0 comp=0x01, line1 comp=0x02 -> phase-1 line=0x01.
//    0xFF/0xFF -> 0xFF, no overflow.
//  3 Same-cycle HS_IN+DE_IN -> that word appears at word 0 of the next output line pair.
//  4 Underrun: RD_HS_IN phase 1 before line 1 committed
//    -> DAT_OUT=0 for the line, ERR_OUT=1 sticky.
//    Clears only on CTL_RUN_IN low.
//  5 Overflow: 5 lines written with no reads -> 5th line dropped, ERR_OUT=1, occ stays 4.
//  6 Async reset asserted mid-line -> all outputs 0 immediately.
//    After release, FSM=S_IDLE, RDY_OUT=0 until 2 new lines committed.

Source files
------------

// File: rtl/prt_scaler_pkg.sv
// prt_scaler_pkg: shared types and constants for the vertical scaler
package prt_scaler_pkg;
  localparam int P_VBS_SLOTS = 4;
  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_RUN} vbs_state_t;
  typedef logic [1:0] vbs_slot_t;
endpackage

// File: rtl/prt_scaler_vbs_lb.sv
// prt_scaler_vbs_lb: four-slot line buffer RAM with one write port and a registered read port
module prt_scaler_vbs_lb
  import prt_scaler_pkg::*;
#(
  parameter int P_ADR = 10,
  parameter int P_DW  = 32,
  localparam int P_AW = $clog2(P_VBS_SLOTS) + P_ADR
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [P_AW-1:0] wr_adr,
  input  logic [P_DW-1:0] wr_dat,
  input  logic [P_AW-1:0] rd_adr,
  output logic [P_DW-1:0] rd_dat
);
  logic [P_DW-1:0] mem_q [2**P_AW];
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_adr] <= wr_dat;
    rd_dat <= mem_q[rd_adr];
  end
endmodule

// File: rtl/prt_scaler_vbs.sv
// prt_scaler_vbs: vertical bilinear 2x up-scaler; each buffered line is emitted as a copy, then
// averaged with its successor, decoupling the input line rate from the doubled output rate
module prt_scaler_vbs
  import prt_scaler_pkg::*;
#(
  parameter int P_PPC        = 4,
  parameter int P_BPC        = 8,
  parameter int P_LINE_WORDS = 1024,
  localparam int P_ADR = $clog2(P_LINE_WORDS),
  localparam int P_DW  = P_PPC * P_BPC,
  localparam int P_RAW = $clog2(P_VBS_SLOTS) + P_ADR
) (
  input  logic            CLK_IN,
  input  logic            RST_IN,
  input  logic            CTL_RUN_IN,
  input  logic [P_ADR:0]  CTL_WORDS_IN,
  input  logic [15:0]     CTL_LINES_IN,
  input  logic            VS_IN,
  input  logic            HS_IN,
  input  logic [P_DW-1:0] DAT_IN,
  input  logic            DE_IN,
  input  logic            RD_VS_IN,
  input  logic            RD_HS_IN,
  input  logic            RD_DE_IN,
  output logic [P_DW-1:0] DAT_OUT,
  output logic            DE_OUT,
  output logic            RDY_OUT,
  output logic            ERR_OUT
);
  vbs_state_t state_q, state_d;
  logic [P_ADR:0] wr_adr_q, wr_adr_d, wa_v, wa_c;
  logic [15:0] wr_line_q, wr_line_d, wl_v, rd_line_q, rd_line_d, b_line, need;
  logic [2:0] occ_q, occ_d, oc_v;
  logic [P_ADR-1:0] rd_adr_q, rd_adr_d, adr;
  logic [P_RAW-1:0] wr_ram_adr, s1_adr_a_q, s1_adr_a_d, s1_adr_b_q, s1_adr_b_d;
  logic [P_DW-1:0] ram_a, ram_b, mix, dat_q, dat_d;
  logic rdy_q, rdy_d, err_q, err_d, phase_q, phase_d, bad_q, bad_d;
  logic s1_de_q, s1_de_d, s1_ph_q, s1_bad_q, s2_de_q, s2_de_d, s2_ph_q, s2_bad_q, de_q, de_d;
  logic clr_w, commit, full, wr_en, ovf, running, start, hs, free, chk, live;
  always_comb begin
    clr_w = VS_IN || !CTL_RUN_IN;
    wl_v = clr_w ? '0 : wr_line_q;
    wa_v = clr_w ? '0 : wr_adr_q;
    oc_v = clr_w ? '0 : occ_q;
    commit = HS_IN && wa_v != '0;
    wr_line_d = wl_v + 16'(commit);
    wa_c = commit ? '0 : wa_v;
    running = state_q == S_RUN;
    start = CTL_RUN_IN && RD_VS_IN && (running || (state_q == S_SYNC && rdy_q));
    hs = CTL_RUN_IN && running && RD_HS_IN && !RD_VS_IN;
    free = hs && phase_q;
    occ_d = oc_v + 3'(commit) - 3'(free && oc_v != '0);
    // occupancy after this cycle's commit/free decides whether the word has a slot to land in
    full = occ_d == 3'(P_VBS_SLOTS);
    wr_en = CTL_RUN_IN && DE_IN && !full && wa_c < CTL_WORDS_IN;
    ovf = CTL_RUN_IN && DE_IN && full;
    wr_ram_adr = {vbs_slot_t'(wr_line_d), wa_c[P_ADR-1:0]};
    wr_adr_d = wa_c + (P_ADR+1)'(wr_en);
    rdy_d = wr_line_d >= 16'd2;
    state_d = !CTL_RUN_IN ? S_IDLE : state_q == S_IDLE ? S_SYNC : start ? S_RUN : state_q;
    live = state_d == S_RUN;
    rd_line_d = (start || !CTL_RUN_IN) ? '0 : rd_line_q + 16'(free);
    phase_d = !(start || !CTL_RUN_IN) && (phase_q ^ hs);
    b_line = rd_line_d == CTL_LINES_IN - 16'd1 ? rd_line_d : rd_line_d + 16'd1;
    need = phase_d ? b_line : rd_line_d;
    chk = start || hs;
    bad_d = CTL_RUN_IN && (chk ? need >= wr_line_d : bad_q);
    err_d = CTL_RUN_IN && (err_q || ovf || (chk && need >= wr_line_d));
    adr = chk ? '0 : rd_adr_q;
    s1_de_d = live && running && RD_DE_IN;
    rd_adr_d = !CTL_RUN_IN ? '0 : adr + P_ADR'(s1_de_d);
    s1_adr_a_d = {vbs_slot_t'(rd_line_d), adr};
    s1_adr_b_d = {vbs_slot_t'(b_line), adr};
    s2_de_d = live && s1_de_q;
    de_d = live && s2_de_q;
    dat_d = (de_d && !s2_bad_q) ? (s2_ph_q ? mix : ram_a) : '0;
  end
  always_comb begin
    mix = '0;
    for (int i = 0; i < P_PPC; i++)
      mix[i*P_BPC +: P_BPC] = P_BPC'(({1'b0, ram_a[i*P_BPC +: P_BPC]} + {1'b0, ram_b[i*P_BPC +: P_BPC]}) >> 1);
  end
  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      state_q <= S_IDLE;
      wr_adr_q <= '0;
      wr_line_q <= '0;
      occ_q <= '0;
      rdy_q <= 1'b0;
      err_q <= 1'b0;
      rd_line_q <= '0;
      phase_q <= 1'b0;
      bad_q <= 1'b0;
      rd_adr_q <= '0;
      s1_de_q <= 1'b0;
      s1_ph_q <= 1'b0;
      s1_bad_q <= 1'b0;
      s1_adr_a_q <= '0;
      s1_adr_b_q <= '0;
      s2_de_q <= 1'b0;
      s2_ph_q <= 1'b0;
      s2_bad_q <= 1'b0;
      de_q <= 1'b0;
      dat_q <= '0;
    end else begin
      state_q <= state_d;
      wr_adr_q <= wr_adr_d;
      wr_line_q <= wr_line_d;
      occ_q <= occ_d;
      rdy_q <= rdy_d;
      err_q <= err_d;
      rd_line_q <= rd_line_d;
      phase_q <= phase_d;
      bad_q <= bad_d;
      rd_adr_q <= rd_adr_d;
      s1_de_q <= s1_de_d;
      s1_ph_q <= phase_d;
      s1_bad_q <= bad_d;
      s1_adr_a_q <= s1_adr_a_d;
      s1_adr_b_q <= s1_adr_b_d;
      s2_de_q <= s2_de_d;
      s2_ph_q <= s1_ph_q;
      s2_bad_q <= s1_bad_q;
      de_q <= de_d;
      dat_q <= dat_d;
    end
  end
  prt_scaler_vbs_lb #(.P_ADR(P_ADR), .P_DW(P_DW)) u_lb_a (
    .clk(CLK_IN), .wr_en(wr_en), .wr_adr(wr_ram_adr), .wr_dat(DAT_IN), .rd_adr(s1_adr_a_q), .rd_dat(ram_a)
  );
  prt_scaler_vbs_lb #(.P_ADR(P_ADR), .P_DW(P_DW)) u_lb_b (
    .clk(CLK_IN), .wr_en(wr_en), .wr_adr(wr_ram_adr), .wr_dat(DAT_IN), .rd_adr(s1_adr_b_q), .rd_dat(ram_b)
  );
  assign DAT_OUT = dat_q;
  assign DE_OUT = de_q;
  assign RDY_OUT = rdy_q;
  assign ERR_OUT = err_q;
endmodule

// File: tb/tb_prt_scaler_vbs.sv
// tb_prt_scaler_vbs: randomized scoreboard bench for the vertical 2x scaler
module tb_prt_scaler_vbs;
  logic CLK_IN = 0, RST_IN = 0, CTL_RUN_IN = 0;
  logic [10:0] CTL_WORDS_IN = 11'd8;
  logic [15:0] CTL_LINES_IN = 16'd4;
  logic VS_IN = 0, HS_IN = 0, DE_IN = 0, RD_VS_IN = 0, RD_HS_IN = 0, RD_DE_IN = 0;
  logic [31:0] DAT_IN = '0;
  logic [31:0] DAT_OUT;
  logic DE_OUT, RDY_OUT, ERR_OUT;
  logic [31:0] exp_q [$];
  logic [31:0] ref_mem [4][16];
  logic [31:0] fill [5];
  int ref_lines, n_tests, n_fail;
  bit err_exp, sb_en = 1;

  prt_scaler_vbs dut (
    .CLK_IN(CLK_IN), .RST_IN(RST_IN), .CTL_RUN_IN(CTL_RUN_IN), .CTL_WORDS_IN(CTL_WORDS_IN),
    .CTL_LINES_IN(CTL_LINES_IN), .VS_IN(VS_IN), .HS_IN(HS_IN), .DAT_IN(DAT_IN), .DE_IN(DE_IN),
    .RD_VS_IN(RD_VS_IN), .RD_HS_IN(RD_HS_IN), .RD_DE_IN(RD_DE_IN),
    .DAT_OUT(DAT_OUT), .DE_OUT(DE_OUT), .RDY_OUT(RDY_OUT), .ERR_OUT(ERR_OUT)
  );

  always #5 CLK_IN = ~CLK_IN;

  task automatic tick();
    @(posedge CLK_IN);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] avg(logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    for (int c = 0; c < 4; c++) r[c*8 +: 8] = 8'((int'(a[c*8 +: 8]) + int'(b[c*8 +: 8])) / 2);
    return r;
  endfunction

  // lines are committed by HS, either on its own cycle or merged with the next line's first word
  task automatic write_frame(int nl, int nw, int extra, bit merge, bit rnd);
    int cur;
    logic [31:0] d;
    VS_IN = 1;
    tick();
    VS_IN = 0;
    ref_lines = 0;
    cur = 0;
    for (int n = 0; n < nl; n++) begin
      for (int w = 0; w < nw + extra; w++) begin
        if ($urandom_range(0, 3) == 0) tick();
        d = rnd ? $urandom : fill[n];
        HS_IN = merge && n > 0 && w == 0;
        if (HS_IN && cur > 0) begin
          ref_lines++;
          cur = 0;
        end
        if (ref_lines == 4) err_exp = 1;
        else if (cur < nw) begin
          ref_mem[ref_lines][cur] = d;
          cur++;
        end
        DE_IN = 1;
        DAT_IN = d;
        tick();
        DE_IN = 0;
        HS_IN = 0;
      end
      if (!merge || n == nl - 1) begin
        HS_IN = 1;
        tick();
        HS_IN = 0;
        if (cur > 0) begin
          ref_lines++;
          cur = 0;
        end
      end
    end
    tick();
    tick();
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      tick();
      t++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick();
    tick();
  endtask

  task automatic read_frame(int nol, int nw);
    int k, bl, need, lines;
    bit bad;
    lines = int'(CTL_LINES_IN);
    RD_VS_IN = 1;
    tick();
    RD_VS_IN = 0;
    for (int j = 0; j < nol; j++) begin
      if (j > 0) begin
        RD_HS_IN = 1;
        tick();
        RD_HS_IN = 0;
      end
      k = j / 2;
      bl = (k == lines - 1) ? k : k + 1;
      need = (j % 2 == 1) ? bl : k;
      bad = need >= ref_lines;
      if (bad) err_exp = 1;
      for (int w = 0; w < nw; w++) begin
        if ($urandom_range(0, 3) == 0) tick();
        exp_q.push_back(bad ? 32'd0 : (j % 2 == 1) ? avg(ref_mem[k][w], ref_mem[bl][w]) : ref_mem[k][w]);
        RD_DE_IN = 1;
        tick();
        RD_DE_IN = 0;
      end
    end
    drain();
  endtask

  initial forever begin
    @(negedge CLK_IN);
    if (sb_en && RST_IN && DE_OUT) begin
      if (exp_q.size() == 0) check("unexpected_de", 32'(DE_OUT), 32'd0);
      else check("dat_out", DAT_OUT, exp_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int nl, nw;
    repeat (3) tick();
    check("rst_dat", DAT_OUT, 32'd0);
    check("rst_de", 32'(DE_OUT), 32'd0);
    check("rst_rdy", 32'(RDY_OUT), 32'd0);
    check("rst_err", 32'(ERR_OUT), 32'd0);
    RST_IN = 1;
    tick();
    CTL_RUN_IN = 1;
    tick();
    tick();
    // copy: line n all components 16*n
    for (int n = 0; n < 4; n++) fill[n] = {4{8'(16 * n)}};
    CTL_LINES_IN = 16'd4;
    CTL_WORDS_IN = 11'd8;
    write_frame(4, 8, 0, 0, 0);
    check("copy_rdy", 32'(RDY_OUT), 32'd1);
    read_frame(8, 8);
    check("copy_err", 32'(ERR_OUT), 32'(err_exp));
    // rounding and saturation-free averaging
    fill[0] = 32'h01010101;
    fill[1] = 32'h02020202;
    CTL_LINES_IN = 16'd2;
    CTL_WORDS_IN = 11'd4;
    write_frame(2, 4, 0, 0, 0);
    read_frame(4, 4);
    fill[0] = 32'hFFFFFFFF;
    fill[1] = 32'hFFFFFFFF;
    write_frame(2, 4, 0, 0, 0);
    read_frame(4, 4);
    // HS merged with the next line's first word
    CTL_LINES_IN = 16'd3;
    CTL_WORDS_IN = 11'd6;
    write_frame(3, 6, 0, 1, 1);
    read_frame(6, 6);
    check("merge_err", 32'(ERR_OUT), 32'(err_exp));
    repeat (12) begin
      nl = $urandom_range(2, 4);
      nw = $urandom_range(1, 16);
      CTL_LINES_IN = 16'(nl);
      CTL_WORDS_IN = 11'(nw);
      write_frame(nl, nw, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1);
      read_frame(2 * nl, nw);
    end
    check("rand_err", 32'(ERR_OUT), 32'(err_exp));
    // underrun: phase 1 of line 0 needs line 1, which never arrives
    CTL_LINES_IN = 16'd2;
    CTL_WORDS_IN = 11'd4;
    write_frame(1, 4, 0, 0, 1);
    check("under_rdy", 32'(RDY_OUT), 32'd0);
    read_frame(2, 4);
    check("under_err", 32'(ERR_OUT), 32'(err_exp));
    write_frame(2, 4, 0, 0, 1);
    read_frame(4, 4);
    check("under_sticky", 32'(ERR_OUT), 32'(err_exp));
    CTL_RUN_IN = 0;
    tick();
    tick();
    err_exp = 0;
    check("runlow_err", 32'(ERR_OUT), 32'(err_exp));
    check("runlow_rdy", 32'(RDY_OUT), 32'd0);
    CTL_RUN_IN = 1;
    tick();
    tick();
    // overflow: fifth line has no free slot
    CTL_LINES_IN = 16'd5;
    CTL_WORDS_IN = 11'd4;
    write_frame(5, 4, 0, 0, 1);
    check("ovf_err", 32'(ERR_OUT), 32'(err_exp));
    read_frame(8, 4);
    // asynchronous reset in the middle of an output line
    sb_en = 0;
    CTL_LINES_IN = 16'd2;
    CTL_WORDS_IN = 11'd8;
    write_frame(2, 8, 0, 0, 1);
    RD_VS_IN = 1;
    tick();
    RD_VS_IN = 0;
    RD_DE_IN = 1;
    repeat (6) tick();
    check("pre_rst_de", 32'(DE_OUT), 32'd1);
    #2 RST_IN = 0;
    #1;
    check("arst_dat", DAT_OUT, 32'd0);
    check("arst_de", 32'(DE_OUT), 32'd0);
    check("arst_rdy", 32'(RDY_OUT), 32'd0);
    check("arst_err", 32'(ERR_OUT), 32'd0);
    RD_DE_IN = 0;
    tick();
    RST_IN = 1;
    tick();
    exp_q.delete();
    err_exp = 0;
    sb_en = 1;
    check("post_rst_rdy", 32'(RDY_OUT), 32'd0);
    write_frame(1, 8, 0, 0, 1);
    check("one_line_rdy", 32'(RDY_OUT), 32'd0);
    write_frame(2, 8, 0, 0, 1);
    check("two_line_rdy", 32'(RDY_OUT), 32'd1);
    read_frame(4, 8);
    check("final_err", 32'(ERR_OUT), 32'(err_exp));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
